// File: rtl/register_file.sv
// MIPS 32 x 32-bit general-purpose register file.
// Two combinational read ports, one rising-edge write port, register 0 hardwired to zero.
// $gp (28) and $sp (29) come out of reset at GP_INIT / SP_INIT; all other registers at 0.
// Reads never bypass a same-cycle write, which keeps the single-cycle datapath loop-free.
// Optional feature macro: REGFILE_DEBUG_PORT_EN adds a third read port (DbgReg/DbgData)
// and a free-running count of committed writes (WriteCount).
module register_file #(
   parameter int unsigned       DATA_W  = 32,
   parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(32'h0000_1800),
   parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'h0000_3FFC)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        ReadReg1,
   input  logic [4:0]        ReadReg2,
   input  logic [4:0]        WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              RegWrite,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
`ifdef REGFILE_DEBUG_PORT_EN
   ,
   input  logic [4:0]        DbgReg,
   output logic [DATA_W-1:0] DbgData,
   output logic [31:0]       WriteCount
`endif
);

   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned GP_IDX   = 28;
   localparam int unsigned SP_IDX   = 29;

   // Register 0 has no storage; only entries 1..31 exist.
   logic [DATA_W-1:0] regs [1:NUM_REGS-1];

   logic write_en;

   // A write commits only for a non-zero destination.
   assign write_en = RegWrite && (WriteReg != ADDR_W'(0));

   // Storage update: async reset loads the boot image, otherwise rising-edge write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (i == GP_IDX)      regs[i] <= GP_INIT;
            else if (i == SP_IDX) regs[i] <= SP_INIT;
            else                  regs[i] <= '0;
         end
      end else if (write_en) begin
         regs[WriteReg] <= WriteData;
      end
   end

   // Combinational read port 1 (no write-through).
   always_comb begin
      ReadData1 = '0;
      if (ReadReg1 != ADDR_W'(0)) ReadData1 = regs[ReadReg1];
   end

   // Combinational read port 2 (no write-through).
   always_comb begin
      ReadData2 = '0;
      if (ReadReg2 != ADDR_W'(0)) ReadData2 = regs[ReadReg2];
   end

`ifdef REGFILE_DEBUG_PORT_EN
   // Debug read port follows the same rules as the functional ports.
   always_comb begin
      DbgData = '0;
      if (DbgReg != ADDR_W'(0)) DbgData = regs[DbgReg];
   end

   // Count of committed writes; wraps naturally at 32 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        WriteCount <= '0;
      else if (write_en) WriteCount <= WriteCount + 32'd1;
   end
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// checked against an array-based reference model.
// Optional feature macro: REGFILE_DEBUG_PORT_EN (debug port and write counter checks).
module tb_register_file;

   localparam int unsigned DATA_W = 32;
   localparam logic [31:0] GP_VAL = 32'h0000_1800;
   localparam logic [31:0] SP_VAL = 32'h0000_3FFC;

   logic              clk;
   logic              rst_n;
   logic [4:0]        ReadReg1, ReadReg2, WriteReg;
   logic [DATA_W-1:0] WriteData;
   logic              RegWrite;
   logic [DATA_W-1:0] ReadData1, ReadData2;
`ifdef REGFILE_DEBUG_PORT_EN
   logic [4:0]        DbgReg;
   logic [DATA_W-1:0] DbgData;
   logic [31:0]       WriteCount;
`endif

   register_file #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .RegWrite  (RegWrite),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2)
`ifdef REGFILE_DEBUG_PORT_EN
      ,
      .DbgReg    (DbgReg),
      .DbgData   (DbgData),
      .WriteCount(WriteCount)
`endif
   );

   // Gated clock so the first reset can be exercised with no clock running.
   logic clk_run;
   initial clk = 1'b0;
   always #5 if (clk_run) clk = ~clk;

   // Reference model: architectural register contents and committed-write count.
   logic [31:0] model [0:31];
   int unsigned wc_model;

   int n_checks;
   int n_pass;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[28] = GP_VAL;
      model[29] = SP_VAL;
      wc_model  = 0;
   endfunction

   // Drive both read ports to one address and compare against the model.
   task automatic check_addr(input string tag, input logic [4:0] a);
      ReadReg1 = a;
      ReadReg2 = a;
`ifdef REGFILE_DEBUG_PORT_EN
      DbgReg = a;
`endif
      #1;
      check($sformatf("%s_rd1_r%0d", tag, a), ReadData1, model[a]);
      check($sformatf("%s_rd2_r%0d", tag, a), ReadData2, model[a]);
`ifdef REGFILE_DEBUG_PORT_EN
      check($sformatf("%s_dbg_r%0d", tag, a), DbgData, model[a]);
`endif
   endtask

   // One clock of write traffic: inputs set on negedge, model updated on posedge.
   task automatic do_write(input logic we, input logic [4:0] wa, input logic [31:0] wd);
      @(negedge clk);
      RegWrite  = we;
      WriteReg  = wa;
      WriteData = wd;
      @(posedge clk);
      if (rst_n && we && wa != 5'd0) begin
         model[wa] = wd;
         wc_model++;
      end
      #1;
      RegWrite = 1'b0;
   endtask

   task automatic check_count(input string tag);
`ifdef REGFILE_DEBUG_PORT_EN
      check(tag, WriteCount, 32'(wc_model));
`else
      if (tag.len() == 0) $display("empty tag");
`endif
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      clk_run   = 1'b0;
      rst_n     = 1'b1;
      RegWrite  = 1'b0;
      WriteReg  = 5'd0;
      WriteData = '0;
      ReadReg1  = 5'd0;
      ReadReg2  = 5'd0;
`ifdef REGFILE_DEBUG_PORT_EN
      DbgReg    = 5'd0;
`endif

      // Reset pulse with the clock stopped.
      #2 rst_n = 1'b0;
      model_reset();
      #3;
      ReadReg1 = 5'd28; ReadReg2 = 5'd29; #1;
      check("rst_gp", ReadData1, GP_VAL);
      check("rst_sp", ReadData2, SP_VAL);
      ReadReg1 = 5'd1; ReadReg2 = 5'd31; #1;
      check("rst_r1", ReadData1, 32'h0);
      check("rst_r31", ReadData2, 32'h0);
      ReadReg1 = 5'd0; ReadReg2 = 5'd5; #1;
      check("rst_r0", ReadData1, 32'h0);
      check("rst_r5", ReadData2, 32'h0);
      check_count("rst_wcount");
      #4 rst_n = 1'b1;
      #2 clk_run = 1'b1;

      // Basic write/read, then a disabled write leaves the value.
      do_write(1'b1, 5'd8, 32'hDEAD_BEEF);
      check_addr("basic", 5'd8);
      check("basic_abs", ReadData1, 32'hDEAD_BEEF);
      do_write(1'b0, 5'd8, 32'h0000_1234);
      check_addr("nowe", 5'd8);
      check("nowe_abs", ReadData2, 32'hDEAD_BEEF);

      // Writes to register 0 are discarded and not counted.
      do_write(1'b1, 5'd0, 32'hFFFF_FFFF);
      check_addr("zero", 5'd0);
      check("zero_abs", ReadData1, 32'h0);
      check_count("zero_wcount");

      // Read-during-write: old value until the edge, new value after.
      do_write(1'b1, 5'd9, 32'd5);
      @(negedge clk);
      RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'd7; ReadReg1 = 5'd9;
      #1 check("rdw_before_a", ReadData1, 32'd5);
      #3 check("rdw_before_b", ReadData1, 32'd5);
      @(posedge clk);
      model[9] = 32'd7;
      wc_model++;
      #1 check("rdw_after", ReadData1, 32'd7);
      RegWrite = 1'b0;

      // Asynchronous reset between edges; writes are ignored while in reset.
      do_write(1'b1, 5'd31, 32'hA5A5_A5A5);
      check_addr("pre_async", 5'd31);
      #2 rst_n = 1'b0;
      model_reset();
      ReadReg1 = 5'd31; ReadReg2 = 5'd28; #1;
      check("async_r31", ReadData1, 32'h0);
      check("async_gp", ReadData2, GP_VAL);
      check_count("async_wcount");
      do_write(1'b1, 5'd5, 32'h1357_9BDF);
      check_addr("rst_nowrite", 5'd5);
      check_count("rst_nowrite_wcount");
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic: check old values before the edge and new ones after.
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         RegWrite  = ($urandom_range(0, 3) != 0);
         WriteReg  = 5'($urandom_range(0, 31));
         WriteData = $urandom;
         ReadReg1  = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
         ReadReg2  = 5'($urandom_range(0, 31));
`ifdef REGFILE_DEBUG_PORT_EN
         DbgReg    = 5'($urandom_range(0, 31));
`endif
         #1;
         check("rand_pre_rd1", ReadData1, model[ReadReg1]);
         check("rand_pre_rd2", ReadData2, model[ReadReg2]);
`ifdef REGFILE_DEBUG_PORT_EN
         check("rand_pre_dbg", DbgData, model[DbgReg]);
`endif
         @(posedge clk);
         if (RegWrite && WriteReg != 5'd0) begin
            model[WriteReg] = WriteData;
            wc_model++;
         end
         #1;
         check("rand_post_rd1", ReadData1, model[ReadReg1]);
         check("rand_post_rd2", ReadData2, model[ReadReg2]);
         check_count("rand_wcount");
      end
      RegWrite = 1'b0;

      // Fresh reset, then full sweep of all registers.
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #2 rst_n = 1'b1;
      for (int i = 1; i < 32; i++) do_write(1'b1, 5'(i), 32'(i) * 32'h0101_0101);
      for (int i = 0; i < 32; i++) begin
         ReadReg1 = 5'(i);
         ReadReg2 = 5'(31 - i);
         #1;
         check($sformatf("sweep_rd1_r%0d", i), ReadData1, (i == 0) ? 32'h0 : 32'(i) * 32'h0101_0101);
         check($sformatf("sweep_rd2_r%0d", 31 - i), ReadData2,
               (i == 31) ? 32'h0 : 32'(31 - i) * 32'h0101_0101);
      end
`ifdef REGFILE_DEBUG_PORT_EN
      check("sweep_wcount", WriteCount, 32'd31);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit MIPS general-purpose register file that sits directly upstream of the ALU.
- Two combinational read ports supply the ALU's A and B operands. ReadData2 reaches B through the datapath's immediate/register operand mux.
- One synchronous write port takes the writeback result: ALU result, memory load data or link address.
- Register 0 is hardwired to zero. $gp and $sp reset to programmable values so the core can run code straight out of reset.

Parameters:
- DATA_W, 32, register width. Fixed at 32 for MIPS; the parameter exists only for lint/bench reuse.
- GP_INIT, 32'h0000_1800, reset value of register 28 ($gp).
- SP_INIT, 32'h0000_3FFC, reset value of register 29 ($sp).

Ports:
- clk  input  1  single core clock; the write port is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- ReadReg1  input  5  address for read port 1 (rs).
- ReadReg2  input  5  address for read port 2 (rt).
- WriteReg  input  5  write address (rd / rt / 31 selected upstream).
- WriteData  input  DATA_W  data to write.
- RegWrite  input  1  write enable.
- ReadData1  output  DATA_W  contents of ReadReg1; feeds ALU A.
- ReadData2  output  DATA_W  contents of ReadReg2; feeds ALU B path and store data.

Behaviour:
Clock and reset:
- One clock domain (clk).
- Reset rst_n is asynchronous and active-low.
- Assertion immediately (no clock edge needed) forces:
  - registers 1..27, 30 and 31 to 0;
  - register 28 to GP_INIT;
  - register 29 to SP_INIT.
- While rst_n is low, writes are ignored.
- Deassertion is clean; the first write can occur on the first rising edge after rst_n goes high.
- Reset asserted mid-write (same cycle as RegWrite=1): reset wins and the write is lost.

Reads:
- Purely combinational, zero latency: ReadDataN = reg[ReadRegN].
- Reading address 0 always returns 0, regardless of any prior writes.
- During and after reset, outputs show the reset contents above, e.g. reading 29 returns SP_INIT, reading 5 returns 0.
- Both ports may address the same register; both return the same value.

Writes:
- On posedge clk, if RegWrite=1 and WriteReg!=0, reg[WriteReg] <= WriteData.
- WriteReg=0 with RegWrite=1 is a legal no-op; register 0 stays 0.
- RegWrite=0 leaves all registers unchanged, whatever WriteReg/WriteData are.

Read-during-write (same register, same cycle):
- Read ports return the OLD value until the rising edge, then the new value.
- No write-through bypass. This is required: in the single-cycle datapath, ReadData -> ALU -> WriteData would otherwise form a combinational loop (e.g. add $t0,$t0,$t1).

Implementation constraints:
- Storage is 31 physical registers; register 0 is not stored.
- No X may propagate from the read outputs after reset.

Optional Feature:
- Macro: REGFILE_DEBUG_PORT_EN.
- Defined:
  - Adds input DbgReg[4:0] and output DbgData[DATA_W-1:0].
  - DbgData is a third combinational read port with the same rules as the functional ports (address 0 -> 0, old value before the edge, reset values honoured).
  - Adds output WriteCount[31:0]: increments by 1 on each rising edge where RegWrite=1 and WriteReg!=0; resets to 0; wraps from 32'hFFFF_FFFF to 0.
- Undefined: these ports and the counter do not exist; functional behaviour is identical.

Test Plan:
- Reset: pulse rst_n low with no clock running -> ReadReg1=28 gives GP_INIT (32'h0000_1800), ReadReg2=29 gives SP_INIT (32'h0000_3FFC), addresses 1 and 31 give 0.
- Basic write/read: RegWrite=1, WriteReg=8, WriteData=32'hDEAD_BEEF, one edge -> ReadReg1=8 and ReadReg2=8 both return 32'hDEAD_BEEF. A later edge with RegWrite=0 and WriteData=32'h1234 leaves 32'hDEAD_BEEF.
- Zero register: write 32'hFFFF_FFFF to WriteReg=0 -> ReadReg1=0 returns 0. With the debug port enabled, WriteCount does not increment.
- Read-during-write: reg9=5; set RegWrite=1, WriteReg=9, WriteData=7, ReadReg1=9 -> ReadData1=5 before the edge, 7 after it, with no intermediate value.
- Async reset mid-run: write 32'hA5A5_A5A5 to reg31, then drop rst_n between clock edges -> reg31 reads 0 without a clock edge. An edge with RegWrite=1 while rst_n=0 does not write.
- Full sweep: write i*32'h0101_0101 to regs 1..31, then read every address on both ports -> each matches, except reg0=0. With REGFILE_DEBUG_PORT_EN defined, WriteCount=31.
